// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential 8-bit ALU stage with iterative shift-add MUL
module alu_seq #(
    parameter int W         = 8,
    parameter int MUL_STEPS = 8
) (
    input  logic         clk,
    input  logic         start,
    input  logic         op_valid,
    input  logic [3:0]   op,
    input  logic [3:0]   dst,
    input  logic [W-1:0] acc_in,
    input  logic [W-1:0] opd_in,
    input  logic [W-1:0] status_in,
    output logic [W-1:0] result,
    output logic         wr_en,
    output logic [3:0]   wr_addr,
    output logic         flag,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(MUL_STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  prod;     // high half: partial sum, low half: remaining multiplier bits
    logic [W-1:0]    mcand;
    logic [3:0]      dst_q;

    logic [W:0]      sum_c;
    logic [W-1:0]    res_c;
    logic            flag_c;
    logic            we_c;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  prod_next;

    // Only the carry-in bit of the status register is consumed.
    logic unused_status;
    assign unused_status = ^status_in[W-1:1];

    // Single-cycle result, evaluated from the live operands at the accept edge.
    always_comb begin
        sum_c  = '0;
        res_c  = result;
        flag_c = flag;
        we_c   = 1'b1;
        case (op)
            OP_ADD: begin
                sum_c  = {1'b0, acc_in} + {1'b0, opd_in};
                res_c  = sum_c[W-1:0];
                flag_c = sum_c[W];
            end
            OP_ADDC: begin
                sum_c  = {1'b0, acc_in} + {1'b0, opd_in} + {{W{1'b0}}, status_in[0]};
                res_c  = sum_c[W-1:0];
                flag_c = sum_c[W];
            end
            OP_SUB: begin
                // Bit W of the zero-extended difference is the unsigned borrow.
                sum_c  = {1'b0, acc_in} - {1'b0, opd_in};
                res_c  = sum_c[W-1:0];
                flag_c = sum_c[W];
            end
            OP_AND: begin
                res_c  = acc_in & opd_in;
                flag_c = ~|(acc_in & opd_in);
            end
            OP_OR: begin
                res_c  = acc_in | opd_in;
                flag_c = ~|(acc_in | opd_in);
            end
            OP_XOR: begin
                res_c  = acc_in ^ opd_in;
                flag_c = ~|(acc_in ^ opd_in);
            end
            OP_SHL: begin
                res_c  = {acc_in[W-2:0], 1'b0};
                flag_c = acc_in[W-1];
            end
            OP_SHR: begin
                res_c  = {1'b0, acc_in[W-1:1]};
                flag_c = acc_in[0];
            end
            OP_CMP: begin
                flag_c = (acc_in == opd_in);
                we_c   = 1'b0;
            end
            default: begin
                we_c   = 1'b0;
            end
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set, then shift right.
    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        prod_next = {mul_sum, prod[W-1:1]};
    end

    // Control FSM with registered outputs; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (start) begin
            state   <= S_IDLE;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= '0;
            dst_q   <= '0;
            result  <= '0;
            wr_addr <= '0;
            flag    <= 1'b0;
            wr_en   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        busy <= 1'b1;
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                            cnt   <= '0;
                            prod  <= {{W{1'b0}}, opd_in};
                            mcand <= acc_in;
                            dst_q <= dst;
                        end else begin
                            state   <= S_RESP;
                            result  <= res_c;
                            flag    <= flag_c;
                            wr_en   <= we_c;
                            wr_addr <= dst;
                            done    <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state   <= S_RESP;
                        result  <= prod_next[W-1:0];
                        flag    <= |prod_next[2*W-1:W];
                        wr_en   <= 1'b1;
                        wr_addr <= dst_q;
                        done    <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       start = 1'b1;
    logic       op_valid = 1'b0;
    logic [3:0] op = 4'd0;
    logic [3:0] dst = 4'd0;
    logic [7:0] acc_in = 8'd0;
    logic [7:0] opd_in = 8'd0;
    logic [7:0] status_in = 8'd0;
    logic [7:0] result;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       flag;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_count = 0;

    typedef struct {
        logic [7:0] res;
        logic       flg;
        logic       we;
        logic [3:0] addr;
        int         at_cyc;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_res = 8'd0;
    logic       m_flag = 1'b0;

    alu_seq #(.W(8), .MUL_STEPS(8)) dut (
        .clk(clk), .start(start), .op_valid(op_valid), .op(op), .dst(dst),
        .acc_in(acc_in), .opd_in(opd_in), .status_in(status_in),
        .result(result), .wr_en(wr_en), .wr_addr(wr_addr), .flag(flag),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic ok,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done) begin
            exp_t e;
            done_count++;
            chk("sb_nonempty", sb.size() > 0, sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("result", result === e.res, result, e.res);
                chk("flag", flag === e.flg, flag, e.flg);
                chk("wr_en", wr_en === e.we, wr_en, e.we);
                chk("wr_addr", wr_addr === e.addr, wr_addr, e.addr);
                chk("busy_in_resp", busy === 1'b1, busy, 1);
                chk("latency", cyc == e.at_cyc, cyc, e.at_cyc);
            end
        end else if (wr_en) begin
            chk("wr_en_without_done", wr_en === 1'b0, wr_en, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] d,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] st);
        int n;
        exp_t e;
        logic [8:0]  t9;
        logic [15:0] p16;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("issue_wait_timeout", busy === 1'b0, busy, 0);
        case (o)
            4'd0: begin t9 = {1'b0, a} + {1'b0, b}; m_res = t9[7:0]; m_flag = t9[8]; end
            4'd1: begin t9 = {1'b0, a} + {1'b0, b} + {8'd0, st[0]}; m_res = t9[7:0]; m_flag = t9[8]; end
            4'd2: begin m_res = a - b; m_flag = (a < b); end
            4'd3: begin m_res = a & b; m_flag = (m_res == 8'd0); end
            4'd4: begin m_res = a | b; m_flag = (m_res == 8'd0); end
            4'd5: begin m_res = a ^ b; m_flag = (m_res == 8'd0); end
            4'd6: begin m_res = a << 1; m_flag = a[7]; end
            4'd7: begin m_res = a >> 1; m_flag = a[0]; end
            4'd8: begin p16 = a * b; m_res = p16[7:0]; m_flag = (p16[15:8] != 8'd0); end
            4'd9: begin m_flag = (a == b); end
            default: ;
        endcase
        e.res    = m_res;
        e.flg    = m_flag;
        e.we     = (o <= 4'd8);
        e.addr   = d;
        e.at_cyc = cyc + 1 + ((o == 4'd8) ? 8 : 0);
        sb.push_back(e);
        op_valid = 1'b1; op = o; dst = d; acc_in = a; opd_in = b; status_in = st;
        tick();
        op_valid = 1'b0;
        acc_in = $urandom_range(0, 255);
        opd_in = $urandom_range(0, 255);
        status_in = $urandom_range(0, 255);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || sb.size() > 0) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("drain_timeout", sb.size() == 0, sb.size(), 0);
    endtask

    initial begin
        int base;
        tick(); tick();
        chk("rst_result", result === 8'h00, result, 8'h00);
        chk("rst_flag", flag === 1'b0, flag, 0);
        chk("rst_wr_en", wr_en === 1'b0, wr_en, 0);
        chk("rst_wr_addr", wr_addr === 4'h0, wr_addr, 0);
        chk("rst_busy", busy === 1'b0, busy, 0);
        chk("rst_done", done === 1'b0, done, 0);
        start = 1'b0;
        tick();

        issue(4'd0, 4'd0, 8'hF0, 8'h20, 8'h00);
        chk("add_result", result === 8'h10, result, 8'h10);
        chk("add_flag", flag === 1'b1, flag, 1);
        chk("add_wr_en", wr_en === 1'b1, wr_en, 1);
        chk("add_done", done === 1'b1, done, 1);
        tick();
        chk("add_after_wr_en", wr_en === 1'b0, wr_en, 0);
        chk("add_after_busy", busy === 1'b0, busy, 0);

        issue(4'd1, 4'd1, 8'h01, 8'h01, 8'h01);
        chk("addc_result", result === 8'h03, result, 8'h03);
        chk("addc_flag", flag === 1'b0, flag, 0);
        issue(4'd2, 4'd2, 8'h05, 8'h07, 8'h00);
        chk("sub_result", result === 8'hFE, result, 8'hFE);
        chk("sub_flag", flag === 1'b1, flag, 1);

        issue(4'd9, 4'd4, 8'h42, 8'h42, 8'h00);
        chk("cmp_flag", flag === 1'b1, flag, 1);
        chk("cmp_wr_en", wr_en === 1'b0, wr_en, 0);
        issue(4'hC, 4'd5, 8'h00, 8'h13, 8'h00);
        chk("nop_flag", flag === 1'b1, flag, 1);
        chk("nop_result", result === 8'hFE, result, 8'hFE);
        chk("nop_done", done === 1'b1, done, 1);

        issue(4'd3, 4'd6, 8'hF0, 8'h0F, 8'h00);
        issue(4'd4, 4'd7, 8'h00, 8'h00, 8'h00);
        issue(4'd5, 4'd3, 8'h5A, 8'hA5, 8'h00);
        issue(4'd7, 4'd1, 8'h81, 8'h00, 8'h00);
        chk("shr_result", result === 8'h40, result, 8'h40);
        issue(4'd6, 4'd2, 8'h81, 8'h00, 8'h00);
        chk("shl_result", result === 8'h02, result, 8'h02);
        chk("shl_flag", flag === 1'b1, flag, 1);
        issue(4'd1, 4'd9, 8'hFF, 8'h00, 8'hFF);
        drain();

        base = done_count;
        issue(4'd8, 4'd8, 8'h10, 8'h11, 8'h00);
        tick(); tick();
        op_valid = 1'b1; op = 4'd0; acc_in = 8'h01; opd_in = 8'h01;
        tick();
        op_valid = 1'b0;
        repeat (5) tick();
        chk("mul_done_cycle9", done === 1'b1, done, 1);
        chk("mul_result", result === 8'h10, result, 8'h10);
        chk("mul_flag", flag === 1'b1, flag, 1);
        op_valid = 1'b1; op = 4'd0;
        tick();
        op_valid = 1'b0;
        repeat (4) tick();
        chk("mul_single_done", (done_count - base) == 1, done_count - base, 1);
        chk("mul_idle_after", busy === 1'b0, busy, 0);

        issue(4'd8, 4'd10, 8'hFF, 8'hFF, 8'h00);
        issue(4'd8, 4'd11, 8'h03, 8'h05, 8'h00);
        issue(4'd8, 4'd12, 8'h00, 8'h9C, 8'h00);
        drain();

        base = done_count;
        issue(4'd8, 4'd13, 8'h37, 8'h29, 8'h00);
        tick(); tick(); tick();
        start = 1'b1;
        sb.delete();
        m_res = 8'h00;
        m_flag = 1'b0;
        tick();
        start = 1'b0;
        chk("abort_result", result === 8'h00, result, 8'h00);
        chk("abort_flag", flag === 1'b0, flag, 0);
        chk("abort_wr_en", wr_en === 1'b0, wr_en, 0);
        chk("abort_wr_addr", wr_addr === 4'h0, wr_addr, 0);
        chk("abort_busy", busy === 1'b0, busy, 0);
        chk("abort_done", done === 1'b0, done, 0);
        issue(4'd0, 4'd14, 8'h22, 8'h33, 8'h00);
        chk("post_abort_add", result === 8'h55, result, 8'h55);
        repeat (12) tick();
        chk("abort_done_count", (done_count - base) == 1, done_count - base, 1);

        start = 1'b1; op_valid = 1'b1; op = 4'd0; acc_in = 8'h10; opd_in = 8'h10;
        tick();
        start = 1'b0; op_valid = 1'b0;
        chk("start_prio_busy", busy === 1'b0, busy, 0);
        chk("start_prio_done", done === 1'b0, done, 0);

        drain();
        chk("sb_empty_at_end", sb.size() == 0, sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential 8-bit ALU stage sitting directly downstream of the register file's read ports and upstream of its write port. It consumes the accumulator (R0), operand-register and status-register (R3) read data, and produces the write-back data, write enable, write address and the flag that the register file latches into R3 every cycle. Single-cycle ops complete with 1-cycle latency. MUL is an iterative 8-step shift-add taking 9 cycles, with a busy handshake toward the issuing control.

## Interface
Parameters:
- W, 8, datapath width (only 8 is supported)
- MUL_STEPS, 8, shift-add iterations for MUL (must equal W)

Ports:
- clk  in  1  clock, all state updates on posedge
- start  in  1  synchronous active-high reset
- op_valid  in  1  issue request, sampled on posedge
- op  in  4  opcode: 0 ADD, 1 ADDC, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 MUL, 9 CMP, 10–15 NOP
- dst  in  4  destination register address
- acc_in  in  8  R0 read data (accumulator)
- opd_in  in  8  operand-register read data
- status_in  in  8  R3 read data; only bit 0 is used, as carry-in for ADDC
- result  out  8  write-back data to the register file
- wr_en  out  1  register-file write enable, one-cycle pulse
- wr_addr  out  4  register-file write address
- flag  out  1  flag to the register file (written into R3 every cycle)
- busy  out  1  not accepting ops
- done  out  1  op-complete pulse

## Operation
- **Acceptance:** an op is accepted at a posedge where op_valid=1 and busy=0. At that edge, op, dst, acc_in, opd_in and status_in[0] are captured internally. An op_valid seen while busy=1 is ignored; there is no queue, so the issuer holds or re-issues the op.
- **States:** IDLE, MUL, RESP. busy = (state != IDLE).
  - IDLE → RESP on accepting any non-MUL op; the result is computed at the accept edge.
  - IDLE → MUL on accepting MUL; step counter is cleared to 0.
  - In MUL, one shift-add step per edge. Counter == MUL_STEPS-1 → RESP.
  - RESP → IDLE unconditionally after one cycle.
- **In RESP:** done=1. wr_en=1 except for CMP and NOP. result and wr_addr=dst are valid.
- **Outside RESP:** wr_en=0 and done=0. result and wr_addr hold their last values.
- **Arithmetic:** 8-bit, wraps modulo 256. The flag is registered and holds its value between completions, because the register file rewrites R3 from flag every cycle.
  - ADD: result = acc+opd; flag = carry out.
  - ADDC: result = acc+opd+cin; flag = carry out.
  - SUB: result = acc-opd; flag = borrow (acc<opd, unsigned).
  - AND / OR / XOR: flag = (result==0).
  - SHL: result = acc<<1; flag = old acc[7].
  - SHR (logical): result = acc>>1; flag = old acc[0].
  - MUL: 16-bit unsigned product of acc×opd; result = low byte; flag = |high byte.
  - CMP: flag = (acc==opd); no write; result is unchanged.
  - NOP: no write; flag and result are unchanged.
- **dst=3:** passed through unchanged. Arbitration between this write and the flag write into R3 belongs to the register file, not this block.
- **Reset (start=1):** state=IDLE, counter=0, result=0, wr_addr=0, flag=0, wr_en=0, done=0, busy=0.
  - Reset during MUL or RESP aborts the op: no wr_en or done is produced for it.
  - start has priority over op_valid on the same edge.

## Timing
- Single-cycle ops: accept at edge E0. The RESP cycle follows E0 (latency 1). The register file writes at E1. busy=1 during that cycle, so the earliest next accept is E2 (throughput 1 op per 2 cycles).
- MUL: accept at E0. Steps occur at E1..E8, and RESP is the cycle after E8 (latency 9). The register-file write is at E9. The earliest next accept is E10.
- Operands are captured only at the accept edge. Register-file changes during busy do not affect the op in flight.
- The flag updates at the edge entering RESP and is stable from then until the next completion or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **ADD:** op=0, acc=0xF0, opd=0x20, dst=0 → next cycle result=0x10, flag=1, wr_en=1, wr_addr=0, done=1, busy=1. The following cycle wr_en=0, busy=0.
- **ADDC and SUB:** ADDC with status_in=0x01, acc=0x01, opd=0x01 → result=0x03, flag=0. SUB with acc=0x05, opd=0x07 → result=0xFE, flag=1.
- **CMP then NOP:** CMP acc=0x42, opd=0x42 → flag=1, wr_en=0, done=1. Then NOP (op=0xC) → done=1, wr_en=0, flag stays 1, result unchanged.
- **MUL:** acc=0x10, opd=0x11 → done exactly 9 cycles after accept, result=0x10, flag=1 (product 0x0110). An op_valid for ADD pulsed at cycles 3 and 9 is ignored, with no extra done.
- **Reset mid-MUL:** start=1 during the 4th MUL step → the next cycle shows all outputs 0 and busy=0, and no done or wr_en ever appears for that MUL. A new ADD issued the following cycle completes normally.
- **SHR / SHL:** SHR acc=0x81 → result=0x40, flag=1. SHL acc=0x81 → result=0x02, flag=1.
